// File: rtl/scan_arbiter_pkg.sv
// Shared constants and types for the scan arbiter.
// Requester count, widths and FSM state encoding.
package scan_arbiter_pkg;

  localparam int NREQ = 32;
  localparam int IDXW = 5;
  localparam int CNTW = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/scan_arbiter_decoder.sv
// Active-low one-hot grant decode of a binary index.
// All lines stay high while the enable is low.
module scan_arbiter_decoder
  import scan_arbiter_pkg::*;
(
  input  logic [IDXW-1:0] idx,
  input  logic            en,
  output logic [NREQ-1:0] gntN
);

  // Drive exactly one line low when enabled
  always_comb begin
    gntN = '1;
    if (en) gntN[idx] = 1'b0;
  end

endmodule

// File: rtl/scan_arbiter.sv
// Rotating-priority 32-way arbiter with hold timeout.
// One guard idle cycle always separates two grants.
module scan_arbiter
  import scan_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic [NREQ-1:0] iReq,
  input  logic            iDone,
  output logic [IDXW-1:0] oGntIdx,
  output logic            oGntValid,
  output logic [NREQ-1:0] oGnt_n,
  output logic            oTimeout
);

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [CNTW-1:0] holdCnt;
  logic [IDXW-1:0] pick;
  logic            found;
  logic            cntMax;
  logic            holderReq;
  logic            relGo;
  logic            toOnly;

  assign cntMax    = (holdCnt == CNTW'(TIMEOUT));
  assign holderReq = iReq[oGntIdx];
  assign relGo     = iDone || !holderReq || cntMax;
  assign toOnly    = cntMax && !iDone && holderReq;
  assign oGntValid = (state == GRANT);

  // First set request at or above ptr, wrapping 31 -> 0
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NREQ; i++) begin
      logic [IDXW-1:0] cand;
      cand = ptr + IDXW'(i);
      if (!found && iReq[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Grant FSM with hold counter and registered timeout pulse
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      ptr      <= '0;
      oGntIdx  <= '0;
      holdCnt  <= '0;
      oTimeout <= 1'b0;
    end else begin
      oTimeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            oGntIdx <= pick;
            holdCnt <= CNTW'(1);
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (relGo) begin
            ptr      <= oGntIdx + IDXW'(1);
            holdCnt  <= '0;
            oTimeout <= toOnly;
            state    <= IDLE;
          end else if (!cntMax) begin
            holdCnt <= holdCnt + CNTW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  scan_arbiter_decoder decoder (
    .idx  (oGntIdx),
    .en   (oGntValid),
    .gntN (oGnt_n)
  );

endmodule

// File: tb/tb_scan_arbiter.sv
// Scoreboard bench for scan_arbiter.
// Directed vectors push per-cycle expectations.
module tb_scan_arbiter;

  logic        iClk;
  logic        iRst;
  logic [31:0] iReq;
  logic        iDone;
  logic [4:0]  oGntIdx;
  logic        oGntValid;
  logic [31:0] oGnt_n;
  logic        oTimeout;

  typedef struct {
    int          cyc;
    string       name;
    logic        valid;
    logic [4:0]  idx;
    logic [31:0] gntN;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nTests = 0;
  int   nFail = 0;

  scan_arbiter #(.TIMEOUT(16)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iReq      (iReq),
    .iDone     (iDone),
    .oGntIdx   (oGntIdx),
    .oGntValid (oGntValid),
    .oGnt_n    (oGnt_n),
    .oTimeout  (oTimeout)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  function automatic logic [31:0] gntOf(logic v, logic [4:0] i);
    logic [31:0] one;
    one = 32'h1;
    return v ? ~(one << i) : 32'hFFFF_FFFF;
  endfunction

  // Monitor: compare DUT outputs against queued expectations
  always @(negedge iClk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      nTests++;
      if (e.cyc != cyc || oGntValid !== e.valid || oGntIdx !== e.idx ||
          oGnt_n !== e.gntN || oTimeout !== e.to) begin
        nFail++;
        $display("FAIL %s cyc=%0d: got v=%b idx=%0d gntN=%h to=%b, want v=%b idx=%0d gntN=%h to=%b",
                 e.name, cyc, oGntValid, oGntIdx, oGnt_n, oTimeout,
                 e.valid, e.idx, e.gntN, e.to);
      end
    end
  end

  task automatic step(input string nm, input logic [31:0] req,
                      input logic done, input logic rst,
                      input logic ev, input logic [4:0] ei,
                      input logic eto);
    exp_t e;
    iReq  = req;
    iDone = done;
    iRst  = rst;
    e.cyc   = cyc + 1;
    e.name  = nm;
    e.valid = ev;
    e.idx   = ei;
    e.gntN  = gntOf(ev, ei);
    e.to    = eto;
    q.push_back(e);
    @(posedge iClk);
    #1;
  endtask

  task automatic stepLit(input string nm, input logic [31:0] req,
                         input logic done, input logic ev,
                         input logic [4:0] ei, input logic [31:0] eg);
    exp_t e;
    iReq  = req;
    iDone = done;
    iRst  = 1'b0;
    e.cyc   = cyc + 1;
    e.name  = nm;
    e.valid = ev;
    e.idx   = ei;
    e.gntN  = eg;
    e.to    = 1'b0;
    q.push_back(e);
    @(posedge iClk);
    #1;
  endtask

  initial begin
    iRst  = 1'b1;
    iReq  = 32'hFFFF_FFFF;
    iDone = 1'b0;
    @(posedge iClk);
    #1;

    step("reset0", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    step("reset1", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    step("idleNoReq", 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    stepLit("single1", 32'h100, 1'b0, 1'b1, 5'd8, 32'hFFFF_FEFF);
    stepLit("single2", 32'h100, 1'b0, 1'b1, 5'd8, 32'hFFFF_FEFF);
    stepLit("single3", 32'h100, 1'b0, 1'b1, 5'd8, 32'hFFFF_FEFF);
    stepLit("singleDone", 32'h100, 1'b1, 1'b0, 5'd8, 32'hFFFF_FFFF);
    step("singleIdle", 32'h0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0);

    step("rotRst", 32'h8000_0001, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step("rotG0", 32'h8000_0001, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
      step("rotR0", 32'h8000_0001, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      step("rotG31", 32'h8000_0001, 1'b0, 1'b0, 1'b1, 5'd31, 1'b0);
      step("rotR31", 32'h8000_0001, 1'b1, 1'b0, 1'b0, 5'd31, 1'b0);
    end
    step("rotIdle", 32'h0, 1'b0, 1'b0, 1'b0, 5'd31, 1'b0);

    step("doneIdle", 32'h0, 1'b1, 1'b0, 1'b0, 5'd31, 1'b0);
    step("toEntry", 32'h4, 1'b1, 1'b0, 1'b1, 5'd2, 1'b0);
    for (int k = 2; k <= 16; k++)
      step("toHold", 32'h4, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0);
    step("toPulse", 32'h4, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
    step("toRegrant", 32'h4, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0);
    step("toDoneRel", 32'h4, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0);

    step("dropG5", 32'h20, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    step("dropOthers", 32'h70, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    step("dropRel", 32'h50, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0);
    step("dropPtr6", 32'h50, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
    step("dropRel6", 32'h50, 1'b1, 1'b0, 1'b0, 5'd6, 1'b0);

    step("mgG20", 32'h0010_0001, 1'b0, 1'b0, 1'b1, 5'd20, 1'b0);
    step("mgHold", 32'h0010_0001, 1'b0, 1'b0, 1'b1, 5'd20, 1'b0);
    step("mgReset", 32'h0010_0001, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    step("mgG0", 32'h0010_0001, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    step("mgRel", 32'h0010_0001, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);

    step("allRst", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k <= 32; k++) begin
      step("allG", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'(k), 1'b0);
      step("allR", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 5'(k), 1'b0);
    end
    step("endIdle", 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge iClk);
    @(negedge iClk);
    #1;
    if (q.size() != 0) begin
      nTests++;
      nFail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_arbiter.md
SCAN_ARBITER -- requirements
Module: scan_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles one grant is held before forced release (range 2..255).
REQ-002 The block SHALL have port iClk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port iRst, input, 1, meaning the synchronous, active-high reset.
REQ-004 The block SHALL have port iReq, input, 32, meaning request lines, bit k = requester k, active-high, level-held.
REQ-005 The block SHALL have port iDone, input, 1, meaning the current grant holder releases the resource this cycle.
REQ-006 The block SHALL have port oGntIdx, output, 5, meaning the binary index of the current grant holder.
REQ-007 The block SHALL have port oGntValid, output, 1, meaning a grant is active.
REQ-008 The block SHALL have port oGnt_n, output, 32, meaning one-hot active-low grant, bit oGntIdx low only while oGntValid=1, else 32'hFFFFFFFF.
REQ-009 The block SHALL have port oTimeout, output, 1, meaning a one-cycle pulse on forced release.

Function
REQ-010 The block SHALL implement states IDLE and GRANT only; encoding 1 bit.
REQ-011 In IDLE with iReq==0, the block SHALL remain in IDLE and keep all outputs at reset values.
REQ-012 In IDLE with iReq!=0, the block SHALL select the first set bit searching upward from pointer ptr (modulo 32, wrap 31->0), register it into oGntIdx and enter GRANT at the same edge.
REQ-013 Latency: a request sampled at edge N SHALL produce oGntValid=1 and the decoded oGnt_n after edge N (one cycle).
REQ-014 oGntValid SHALL equal (state==GRANT); oGnt_n SHALL be the combinational decode of registered oGntIdx gated by oGntValid.
REQ-015 In GRANT, a hold counter SHALL start at 1 on entry and increment each cycle, 8 bits wide, saturating at TIMEOUT.
REQ-016 In GRANT, release SHALL occur at the edge where any of: iDone=1, iReq[oGntIdx]=0, or hold counter==TIMEOUT.
REQ-017 On release the block SHALL set ptr = oGntIdx+1 (5-bit wrap, 31 -> 0) and return to IDLE; oGntIdx SHALL hold its last value.
REQ-018 Every release SHALL be followed by exactly one IDLE cycle with oGntValid=0 (guard slot); back-to-back grants are separated by one cycle.
REQ-019 oTimeout SHALL pulse for one cycle, registered, only when release is caused solely by the counter (iDone=0 and iReq[oGntIdx]=1 at that edge).
REQ-020 iDone SHALL be ignored in IDLE.
REQ-021 Requests from requesters other than the holder SHALL NOT affect an active grant.
REQ-022 With all 32 requesters continuously asserted, grants SHALL rotate 0,1,...,31,0 with no requester granted twice before every other has been granted once.

Reset
REQ-023 When iRst=1 at a rising edge the block SHALL enter IDLE, set ptr=0, oGntIdx=0, oGntValid=0, oGnt_n=32'hFFFFFFFF, oTimeout=0, hold counter=0.
REQ-024 Reset SHALL take priority over every other condition, including mid-grant; no release pointer update occurs on a reset edge.
REQ-025 The first request after reset SHALL be searched from index 0.

Structure
REQ-026 State encodings, the requester count (32), index width (5) and counter width (8) SHALL be constants in the shared package.
REQ-027 The active-low 5-to-32 grant decode SHALL be one sub-module instance, decoder, driven by oGntIdx with enable oGntValid.
REQ-028 The rotating priority search SHALL be combinational logic inside scan_arbiter, not a separate module.

Verification
REQ-029 Reset: iRst=1 for 2 cycles with iReq=32'hFFFFFFFF -> oGntValid=0, oGnt_n=32'hFFFFFFFF, oGntIdx=0 throughout.
REQ-030 Single grant: iReq=32'h0000_0100 at edge N -> after N, oGntIdx=8, oGnt_n=32'hFFFF_FEFF; iDone=1 at N+3 -> oGnt_n=32'hFFFFFFFF after N+3.
REQ-031 Rotation/wrap: iReq=32'h8000_0001, iDone pulsed each grant -> grants 0,31,0,31 with one idle cycle between each.
REQ-032 Timeout: TIMEOUT=16, iReq=32'h0000_0004 held, iDone=0 -> grant held 16 cycles, oTimeout pulses once at release, next grant again index 2 after one idle cycle.
REQ-033 Request drop: holder 5 deasserts iReq[5] mid-grant -> release at that edge, oTimeout=0, ptr=6.
REQ-034 Reset mid-grant: iRst=1 while oGntIdx=20 -> next cycle IDLE, oGnt_n=32'hFFFFFFFF; with iReq=32'h0010_0001 the next grant is index 0.
